// File: rtl/alarm_clk_pio_pkg.sv
// Shared constants and helpers for the alarm-clock PIO bank.
package alarm_clk_pio_pkg;

    localparam logic [1:0] OFF_DATA  = 2'd0;
    localparam logic [1:0] OFF_SET   = 2'd1;
    localparam logic [1:0] OFF_CLR   = 2'd2;
    localparam logic [1:0] OFF_BLINK = 2'd3;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

endpackage

// File: rtl/alarm_clk_blink_gen.sv
// Blink timebase: prescaler plus visible/dark phase flag, restartable by software.
module alarm_clk_blink_gen
    import alarm_clk_pio_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase
);

    // Keep at least one prescaler bit so BLINK_DIV = 1 still elaborates.
    localparam int unsigned PW = (clog2(BLINK_DIV) < 1) ? 1 : clog2(BLINK_DIV);
    localparam logic [PW-1:0] LAST = PW'(BLINK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          phase_q, phase_d;

    // Restart beats a coincident wrap, so no toggle happens on that edge.
    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        if (restart) begin
            presc_d = '0;
            phase_d = 1'b1;
        end else if (presc_q == LAST) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            phase_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/alarm_clk_pio_bank.sv
// Avalon-MM bank of WIDTH-bit output channels with set/clear access and hardware blink.
module alarm_clk_pio_bank
    import alarm_clk_pio_pkg::*;
#(
    parameter int unsigned       CHANNELS    = 6,
    parameter int unsigned       WIDTH       = 4,
    parameter int unsigned       BLINK_DIV   = 25_000_000,
    parameter logic [WIDTH-1:0]  BLANK_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [clog2(CHANNELS)+1:0]    address,
    input  logic                          chipselect,
    input  logic                          write_n,
    input  logic [31:0]                   writedata,
    output logic [31:0]                   readdata,
    output logic [CHANNELS*WIDTH-1:0]     out_port
);

    logic [31:0]                    ch_idx;
    logic [1:0]                     offset;
    logic                           ch_valid;
    logic                           wr_en;
    logic                           restart;
    logic                           phase;
    logic [WIDTH-1:0]               wdata;
    logic [CHANNELS-1:0][WIDTH-1:0] data_all;
    logic [CHANNELS-1:0]            blink_all;
    logic                           unused_wdata;

    assign ch_idx       = 32'(address >> 2);
    assign offset       = address[1:0];
    assign ch_valid     = ch_idx < CHANNELS;
    assign wr_en        = chipselect && !write_n && ch_valid;
    assign restart      = wr_en && (offset == OFF_BLINK);
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    alarm_clk_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .phase   (phase)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] data_q, data_d;
        logic             blink_q, blink_d;
        logic             sel;

        assign sel = wr_en && (ch_idx == 32'(c));

        always_comb begin
            data_d  = data_q;
            blink_d = blink_q;
            if (sel) begin
                case (offset)
                    OFF_DATA: data_d  = wdata;
                    OFF_SET:  data_d  = data_q | wdata;
                    OFF_CLR:  data_d  = data_q & ~wdata;
                    default:  blink_d = writedata[0];
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                data_q  <= '0;
                blink_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                blink_q <= blink_d;
            end
        end

        assign data_all[c]  = data_q;
        assign blink_all[c] = blink_q;
        assign out_port[c*WIDTH +: WIDTH] = (blink_q && !phase) ? BLANK_VALUE : data_q;
    end

    // Out-of-range channels fall through to zero.
    always_comb begin
        readdata = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_idx == c) begin
                if (offset == OFF_BLINK) readdata = {30'b0, phase, blink_all[c]};
                else                     readdata = 32'(data_all[c]);
            end
        end
    end

endmodule

// File: tb/tb_alarm_clk_pio_bank.sv
// Directed self-checking bench for alarm_clk_pio_bank (6 x 4-bit channels, BLINK_DIV = 4).
module tb_alarm_clk_pio_bank;

    localparam int unsigned CHANNELS = 6;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned DIV      = 4;
    localparam logic [3:0]  BLANK    = 4'hB;

    logic        clk;
    logic        reset;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [23:0] out_port;

    int checks = 0;
    int errors = 0;

    alarm_clk_pio_bank #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .BLINK_DIV   (DIV),
        .BLANK_VALUE (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: drives a write, returns at the next negedge with the write still driven.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        address   = '0;
        writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_port !== 24'h0) begin
            errors++;
            $display("FAIL reset_out_port: got %h want %h", out_port, 24'h0);
        end
        address = {3'd2, 2'd3};
        #1;
        checks++;
        if (readdata !== 32'h2) begin
            errors++;
            $display("FAIL reset_blink_reg: got %h want %h", readdata, 32'h2);
        end
    endtask

    task automatic test_set_clr();
        logic [4:0]  addrs [3];
        logic [31:0] wvals [3];
        logic [3:0]  exp   [3];
        addrs = '{5'd4, 5'd5, 5'd6};
        wvals = '{32'h5, 32'hA, 32'h3};
        exp   = '{4'h5, 4'hF, 4'hC};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wr(addrs[i], wvals[i]);
            checks++;
            if (readdata !== 32'(exp[i])) begin
                errors++;
                $display("FAIL rmw_readdata[%0d]: got %h want %h", i, readdata, exp[i]);
            end
            checks++;
            if (out_port[7:4] !== exp[i]) begin
                errors++;
                $display("FAIL rmw_out_port[%0d]: got %h want %h", i, out_port[7:4], exp[i]);
            end
        end
        idle();
    endtask

    // Starting at the negedge of cycle 1 after a restart, checks n cycles of the blink pattern.
    task automatic check_blink(input string tag, input int n);
        logic       vis;
        logic [3:0] e0;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            vis = (((k - 1) / DIV) % 2) == 0;
            e0  = vis ? 4'h7 : BLANK;
            checks++;
            if (out_port[3:0] !== e0) begin
                errors++;
                $display("FAIL %s_ch0 k=%0d: got %h want %h", tag, k, out_port[3:0], e0);
            end
            checks++;
            if (out_port[7:4] !== 4'hC) begin
                errors++;
                $display("FAIL %s_ch1_steady k=%0d: got %h want %h", tag, k, out_port[7:4], 4'hC);
            end
            checks++;
            if (readdata !== (vis ? 32'h3 : 32'h1)) begin
                errors++;
                $display("FAIL %s_phase_reg k=%0d: got %h want %h", tag, k, readdata,
                         vis ? 32'h3 : 32'h1);
            end
        end
    endtask

    task automatic test_blink();
        wr(5'd0, 32'h7);
        wr(5'd3, 32'h1);
        idle();
        check_blink("blink", 12);
    endtask

    // Cycle 12 holds the last prescaler count, so this write lands on a visible->dark wrap.
    task automatic test_back_to_back();
        wr(5'd3, 32'h1);
        idle();
        check_blink("wrap_restart", 8);
    endtask

    task automatic test_out_of_range();
        wr(5'd3, 32'h0);
        wr({3'd7, 2'd0}, 32'hF);
        wr({3'd7, 2'd1}, 32'hF);
        wr({3'd7, 2'd3}, 32'h1);
        idle();
        repeat (5) @(negedge clk);
        checks++;
        if (out_port !== 24'h0000C7) begin
            errors++;
            $display("FAIL oor_out_port: got %h want %h", out_port, 24'h0000C7);
        end
        address = {3'd7, 2'd0};
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_read7: got %h want %h", readdata, 32'h0);
        end
        address = {3'd6, 2'd3};
        #1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_read6_blink: got %h want %h", readdata, 32'h0);
        end
    endtask

    task automatic test_reset_mid_blink();
        @(negedge clk);
        wr(5'd3, 32'h1);
        idle();
        repeat (DIV) @(negedge clk);
        checks++;
        if (out_port[3:0] !== BLANK) begin
            errors++;
            $display("FAIL pre_reset_dark: got %h want %h", out_port[3:0], BLANK);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_port !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset_out_port: got %h want %h", out_port, 24'h0);
        end
        checks++;
        if (readdata !== 32'h2) begin
            errors++;
            $display("FAIL mid_reset_phase: got %h want %h", readdata, 32'h2);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_set_clr();
        test_blink();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
